mxint_broadcast_stream: RTL and testbench

Parametrised, streaming successor to the combinational MXINT8 broadcast. Takes one float32 scalar per valid/ready transaction and quantises it once to an E8M0 shared scale plus a two's-complement MXINT element of configurable width. It then streams the BLOCK_SIZE-element MX block out LANES elements per beat. Sits between scalar producers and the MX ALU datapath; selectable rounding and an overflow flag are new relative to the fixed MXINT8 version.

---
 rtl/mx_pkg.sv | 18 +
 rtl/mxint_scalar_quant.sv | 63 ++++++
 rtl/mxint_broadcast_stream.sv | 120 ++++++++++++
 tb/tb_mxint_broadcast_stream.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mx_pkg.sv
// Shared constants and enums for the MX conversion / streaming blocks.
package mx_pkg;

  localparam int unsigned FLOAT32_WIDTH = 32;
  localparam int unsigned SCALE_WIDTH   = 8;
  localparam logic [SCALE_WIDTH-1:0] E8M0_NAN = 8'hFF;

  typedef enum logic {
    RND_RNE   = 1'b0,
    RND_TRUNC = 1'b1
  } round_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

endpackage

// File: rtl/mxint_scalar_quant.sv
// Combinational float32 -> (E8M0 scale, MXINT element) quantiser for a single scalar.
module mxint_scalar_quant
  import mx_pkg::*;
#(
  parameter int unsigned ELEM_WIDTH = 8
) (
  input  logic [FLOAT32_WIDTH-1:0] float32,
  input  round_mode_e              round_mode,
  output logic [SCALE_WIDTH-1:0]   scale,
  output logic [ELEM_WIDTH-1:0]    element,
  output logic                     overflow
);

  // Normals carry the hidden 1 at bit 23; element LSB weight is 2^-(ELEM_WIDTH-2).
  localparam int unsigned NORM_SHIFT = 25 - ELEM_WIDTH;
  localparam int unsigned SUB_SHIFT  = 24 - ELEM_WIDTH;
  localparam logic [24:0] MAG_LIMIT  = 25'(1) << (ELEM_WIDTH - 1);

  function automatic logic [24:0] shift_round(input logic [23:0] sig,
                                              input int unsigned sh,
                                              input logic trunc);
    logic [23:0] rem;
    logic [23:0] half;
    logic [24:0] q;
    q    = {1'b0, sig >> sh};
    rem  = sig & ((24'd1 << sh) - 24'd1);
    half = 24'd1 << (sh - 1);
    if (!trunc && ((rem > half) || ((rem == half) && q[0]))) q = q + 25'd1;
    return q;
  endfunction

  logic        sign;
  logic [7:0]  exp_f;
  logic [22:0] frac;
  logic        trunc;
  logic [24:0] mag;

  assign sign  = float32[31];
  assign exp_f = float32[30:23];
  assign frac  = float32[22:0];
  assign trunc = (round_mode == RND_TRUNC);

  always_comb begin
    scale    = '0;
    element  = '0;
    overflow = 1'b0;
    mag      = '0;
    if (exp_f == '1) begin
      scale    = E8M0_NAN;
      overflow = (frac == '0);
    end else if ((exp_f != '0) || (frac != '0)) begin
      scale = exp_f;
      if (exp_f == '0) mag = shift_round({1'b0, frac}, SUB_SHIFT, trunc);
      else             mag = shift_round({1'b1, frac}, NORM_SHIFT, trunc);
      if (mag >= MAG_LIMIT) begin
        mag      = MAG_LIMIT - 25'd1;
        overflow = 1'b1;
      end
      element = sign ? -mag[ELEM_WIDTH-1:0] : mag[ELEM_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mxint_broadcast_stream.sv
// Accepts one float32 scalar per handshake, quantises it once and streams the
// resulting MX block out LANES identical elements per beat.
module mxint_broadcast_stream #(
  parameter int unsigned ELEM_WIDTH  = 8,
  parameter int unsigned BLOCK_SIZE  = 32,
  parameter int unsigned LANES       = 8,
  parameter int unsigned SCALE_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [31:0]                          i_float32,
  input  logic                                 i_round_mode,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output logic [SCALE_WIDTH-1:0]               o_scale,
  output logic [LANES-1:0][ELEM_WIDTH-1:0]     o_mxint_elements,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic                                 o_first,
  output logic                                 o_last,
  output logic                                 o_overflow
);
  import mx_pkg::*;

  localparam int unsigned BEATS = BLOCK_SIZE / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((BLOCK_SIZE % LANES) != 0 || LANES == 0 || BEATS == 0) begin : g_bad_block
      $error("mxint_broadcast_stream: BLOCK_SIZE must be a non-zero multiple of LANES");
    end
    if (ELEM_WIDTH < 2 || ELEM_WIDTH > 8) begin : g_bad_width
      $error("mxint_broadcast_stream: ELEM_WIDTH must be in 2..8");
    end
    if (SCALE_WIDTH < mx_pkg::SCALE_WIDTH) begin : g_bad_scale
      $error("mxint_broadcast_stream: SCALE_WIDTH too small for E8M0");
    end
  endgenerate

  logic [mx_pkg::SCALE_WIDTH-1:0] q_scale;
  logic [ELEM_WIDTH-1:0]          q_elem;
  logic                           q_ovf;

  mxint_scalar_quant #(
    .ELEM_WIDTH (ELEM_WIDTH)
  ) u_quant (
    .float32    (i_float32),
    .round_mode (round_mode_e'(i_round_mode)),
    .scale      (q_scale),
    .element    (q_elem),
    .overflow   (q_ovf)
  );

  stream_state_e          state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [SCALE_WIDTH-1:0] scale_q, scale_nx;
  logic [ELEM_WIDTH-1:0]  elem_q, elem_nx;
  logic                   ovf_q, ovf_nx;
  logic                   beat_fire;
  logic                   accept;

  assign o_valid   = (state == ST_STREAM);
  assign o_first   = o_valid && (cnt == '0);
  assign o_last    = o_valid && (cnt == LAST_BEAT);
  assign beat_fire = o_valid && i_ready;
  assign o_ready   = (state == ST_IDLE) || (beat_fire && o_last);
  assign accept    = i_valid && o_ready;

  assign o_scale          = scale_q;
  assign o_overflow       = ovf_q;
  assign o_mxint_elements = {LANES{elem_q}};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    scale_nx = scale_q;
    elem_nx  = elem_q;
    ovf_nx   = ovf_q;
    unique case (state)
      ST_IDLE: ;
      ST_STREAM: begin
        if (beat_fire) begin
          if (cnt == LAST_BEAT) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // A load overrides the end-of-block return to IDLE, so back-to-back blocks have no bubble.
    if (accept) begin
      state_nx = ST_STREAM;
      cnt_nx   = '0;
      scale_nx = SCALE_WIDTH'(q_scale);
      elem_nx  = q_elem;
      ovf_nx   = q_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      scale_q <= '0;
      elem_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      scale_q <= scale_nx;
      elem_q  <= elem_nx;
      ovf_q   <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_mxint_broadcast_stream.sv
// Directed + randomized bench for mxint_broadcast_stream against a real-arithmetic reference.
module tb_mxint_broadcast_stream;

  localparam int BEATS = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     i_float32;
  logic            i_round_mode;
  logic            i_valid;
  logic            o_ready;
  logic [7:0]      o_scale;
  logic [7:0][7:0] o_mxint_elements;
  logic            o_valid;
  logic            i_ready;
  logic            o_first;
  logic            o_last;
  logic            o_overflow;

  logic [31:0]     i_float32_4;
  logic            i_round_mode_4;
  logic            i_valid_4;
  logic            o_ready_4;
  logic [7:0]      o_scale_4;
  logic [3:0][3:0] o_mxint_elements_4;
  logic            o_valid_4;
  logic            i_ready_4;
  logic            o_first_4;
  logic            o_last_4;
  logic            o_overflow_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mxint_broadcast_stream dut (
    .clk              (clk),
    .rst              (rst),
    .i_float32        (i_float32),
    .i_round_mode     (i_round_mode),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .o_scale          (o_scale),
    .o_mxint_elements (o_mxint_elements),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_first          (o_first),
    .o_last           (o_last),
    .o_overflow       (o_overflow)
  );

  mxint_broadcast_stream #(
    .ELEM_WIDTH (4),
    .BLOCK_SIZE (8),
    .LANES      (4)
  ) dut4 (
    .clk              (clk),
    .rst              (rst),
    .i_float32        (i_float32_4),
    .i_round_mode     (i_round_mode_4),
    .i_valid          (i_valid_4),
    .o_ready          (o_ready_4),
    .o_scale          (o_scale_4),
    .o_mxint_elements (o_mxint_elements_4),
    .o_valid          (o_valid_4),
    .i_ready          (i_ready_4),
    .o_first          (o_first_4),
    .o_last           (o_last_4),
    .o_overflow       (o_overflow_4)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Reference: value = 1.m * 2^(ew-2) (normal) or 0.m * 2^(ew-1) (subnormal), rounded in reals.
  function automatic void model(input logic [31:0] f, input logic rm, input int ew,
                                output logic [7:0] sc, output int el, output logic ov);
    int  e, m, mag;
    real x, fl, d;
    e  = int'(f[30:23]);
    m  = int'(f[22:0]);
    sc = 8'h00;
    el = 0;
    ov = 1'b0;
    if (e == 255) begin
      sc = 8'hFF;
      ov = (m == 0);
    end else if (e != 0 || m != 0) begin
      sc = f[30:23];
      if (e == 0) x = real'(m) / real'(1 << (24 - ew));
      else        x = real'(m + (1 << 23)) / real'(1 << (25 - ew));
      fl  = $floor(x);
      mag = $rtoi(fl);
      d   = x - fl;
      if (!rm && (d > 0.5 || (d == 0.5 && (mag % 2) == 1))) mag++;
      if (mag >= (1 << (ew - 1))) begin
        mag = (1 << (ew - 1)) - 1;
        ov  = 1'b1;
      end
      el = f[31] ? -mag : mag;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic lanes_equal();
    for (int i = 1; i < 8; i++)
      if (o_mxint_elements[i] !== o_mxint_elements[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_beat(input logic [7:0] sc, input logic [7:0] el, input logic ov,
                            input logic first, input logic last);
    check("valid", 32'(o_valid), 32'(1'b1));
    check("scale", 32'(o_scale), 32'(sc));
    check("elem", 32'(o_mxint_elements[0]), 32'(el));
    check("lanes", 32'(lanes_equal()), 32'(1'b1));
    check("first", 32'(o_first), 32'(first));
    check("last", 32'(o_last), 32'(last));
    check("ovf", 32'(o_overflow), 32'(ov));
  endtask

  task automatic check_cleared();
    check("rst_valid", 32'(o_valid), 32'(1'b0));
    check("rst_ready", 32'(o_ready), 32'(1'b1));
    check("rst_scale", 32'(o_scale), 32'(8'h00));
    check("rst_elem", 32'(o_mxint_elements), 32'(0));
    check("rst_first", 32'(o_first), 32'(1'b0));
    check("rst_last", 32'(o_last), 32'(1'b0));
    check("rst_ovf", 32'(o_overflow), 32'(1'b0));
  endtask

  task automatic send(input logic [31:0] f, input logic rm);
    int n = 0;
    @(negedge clk);
    i_float32    = f;
    i_round_mode = rm;
    i_valid      = 1'b1;
    while (!o_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(o_ready), 32'(1'b1));
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic expect_block(input logic [31:0] f, input logic rm);
    logic [7:0] sc;
    int         el;
    logic       ov;
    int         n;
    model(f, rm, 8, sc, el, ov);
    for (int b = 0; b < BEATS; b++) begin
      @(negedge clk);
      n = 0;
      while (!o_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_beat(sc, el[7:0], ov, b == 0, b == BEATS - 1);
    end
  endtask

  initial begin
    logic [7:0]  sc, sc2;
    int          el, el2;
    logic        ov, ov2;
    logic [31:0] f;
    logic        rm;

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_float32 = '0; i_round_mode = 1'b0;
    i_valid_4 = 1'b0; i_ready_4 = 1'b1; i_float32_4 = '0; i_round_mode_4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_cleared();

    // 1.0, latency and framing
    send(32'h3F800000, 1'b0);
    check("latency_valid", 32'(o_valid), 32'(1'b1));
    expect_block(32'h3F800000, 1'b0);
    check("elem_1p0", 32'(o_mxint_elements[0]), 32'h40);

    // signed, subnormal, overflow and rounding-mode cases
    send(32'hBFC00000, 1'b0); expect_block(32'hBFC00000, 1'b0);
    check("elem_m1p5", 32'(o_mxint_elements[0]), 32'hA0);
    send(32'h00400000, 1'b0); expect_block(32'h00400000, 1'b0);
    send(32'h3FFFFFFF, 1'b0); expect_block(32'h3FFFFFFF, 1'b0);
    check("sat_rne_ovf", 32'(o_overflow), 32'(1'b1));
    send(32'h3FFFFFFF, 1'b1); expect_block(32'h3FFFFFFF, 1'b1);
    check("trunc_ovf", 32'(o_overflow), 32'(1'b0));
    send(32'h7F800000, 1'b0); expect_block(32'h7F800000, 1'b0);
    send(32'h7FC00000, 1'b0); expect_block(32'h7FC00000, 1'b0);
    send(32'h00000000, 1'b0); expect_block(32'h00000000, 1'b0);
    send(32'h80000000, 1'b0); expect_block(32'h80000000, 1'b0);
    send(32'h3F808000, 1'b0); expect_block(32'h3F808000, 1'b0);
    send(32'h3F818000, 1'b0); expect_block(32'h3F818000, 1'b0);

    // backpressure: stall three cycles on beat 1
    model(32'hBFC00000, 1'b0, 8, sc, el, ov);
    send(32'hBFC00000, 1'b0);
    @(negedge clk); check_beat(sc, el[7:0], ov, 1'b1, 1'b0);
    @(negedge clk); check_beat(sc, el[7:0], ov, 1'b0, 1'b0);
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_beat(sc, el[7:0], ov, 1'b0, 1'b0);
      check("stall_ready", 32'(o_ready), 32'(1'b0));
    end
    i_ready = 1'b1;
    @(negedge clk); check_beat(sc, el[7:0], ov, 1'b0, 1'b0);
    @(negedge clk); check_beat(sc, el[7:0], ov, 1'b0, 1'b1);

    // back-to-back blocks: new scalar offered on the last beat
    model(32'h3F800000, 1'b0, 8, sc, el, ov);
    model(32'hC0400000, 1'b0, 8, sc2, el2, ov2);
    send(32'h3F800000, 1'b0);
    for (int b = 0; b < 2 * BEATS; b++) begin
      @(negedge clk);
      if (b < BEATS - 1) check("b2b_ready_low", 32'(o_ready), 32'(1'b0));
      if (b == BEATS - 1) begin
        check("b2b_ready_high", 32'(o_ready), 32'(1'b1));
        i_float32 = 32'hC0400000;
        i_valid   = 1'b1;
      end
      if (b < BEATS) check_beat(sc, el[7:0], ov, b == 0, b == BEATS - 1);
      else           check_beat(sc2, el2[7:0], ov2, b == BEATS, b == 2 * BEATS - 1);
      if (b == BEATS - 1) begin
        @(posedge clk);
        #1 i_valid = 1'b0;
      end
    end

    // reset mid-stream during beat 2
    model(32'hBFC00000, 1'b0, 8, sc, el, ov);
    send(32'hBFC00000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); check_beat(sc, el[7:0], ov, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_cleared();
    send(32'h3F800000, 1'b0); expect_block(32'h3F800000, 1'b0);

    // randomized scalars, biased toward subnormal and special exponents
    for (int t = 0; t < 24; t++) begin
      f  = $urandom;
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: f[30:23] = 8'h00;
        1: f[30:23] = 8'hFF;
        default: ;
      endcase
      send(f, rm);
      expect_block(f, rm);
    end

    // narrow elements: ELEM_WIDTH=4, two beats per block
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin f = 32'h3F800000; rm = 1'b0; end
      else begin f = $urandom; rm = 1'($urandom_range(0, 1)); end
      model(f, rm, 4, sc, el, ov);
      @(negedge clk);
      check("n4_ready", 32'(o_ready_4), 32'(1'b1));
      i_float32_4 = f; i_round_mode_4 = rm; i_valid_4 = 1'b1;
      @(posedge clk);
      #1 i_valid_4 = 1'b0;
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        check("n4_valid", 32'(o_valid_4), 32'(1'b1));
        check("n4_scale", 32'(o_scale_4), 32'(sc));
        check("n4_elem0", 32'(o_mxint_elements_4[0]), 32'(el[3:0]));
        check("n4_elem3", 32'(o_mxint_elements_4[3]), 32'(el[3:0]));
        check("n4_ovf", 32'(o_overflow_4), 32'(ov));
        check("n4_first", 32'(o_first_4), 32'(b == 0));
        check("n4_last", 32'(o_last_4), 32'(b == 1));
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
